// File: rtl/warmboot_sequencer_if.sv
// Signal bundle between the board buttons / display / SB_WARMBOOT and the sequencer.
// Buttons are raw levels and image_changed is a one-cycle strobe, so there is no valid/ready handshake.
interface warmboot_sequencer_if;
  logic       btn_inc;
  logic       btn_boot;
  logic [1:0] image;
  logic       image_changed;
  logic       boot_s0;
  logic       boot_s1;
  logic       boot;
  logic       busy;
  logic [1:0] state;

  modport master (
    output btn_inc, btn_boot,
    input  image, image_changed, boot_s0, boot_s1, boot, busy, state
  );

  modport slave (
    input  btn_inc, btn_boot,
    output image, image_changed, boot_s0, boot_s1, boot, busy, state
  );
endinterface

// File: rtl/warmboot_sequencer.sv
// Debounces two push-buttons, cycles the selected warm-boot image and fires
// SB_WARMBOOT after holding S1:S0 stable for SETUP_CYCLES clocks.
module warmboot_sequencer #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int SETUP_CYCLES    = 16,
  parameter int NUM_IMAGES      = 4
) (
  input logic            clk,
  input logic            rst,
  warmboot_sequencer_if.slave bus
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int CW = (SETUP_CYCLES > 0) ? $clog2(SETUP_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES);
  localparam logic [1:0]    IMG_LAST   = 2'(NUM_IMAGES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, FIRE = 2'd2} state_t;

  state_t state, state_n;

  // Bit 0 is the increment button, bit 1 the boot button.
  logic [1:0]    raw, sync1, sync2, db, db_prev, ev;
  logic [DW-1:0] db_cnt [2];

  logic [1:0]    image, image_n;
  logic [1:0]    sel, sel_n;
  logic          changed, changed_n;
  logic          boot_r, boot_n;
  logic          busy_r, busy_n;
  logic [CW-1:0] cnt, cnt_n;

  assign raw = {bus.btn_boot, bus.btn_inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      db        <= '0;
      db_prev   <= '0;
      ev        <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      db_prev <= db;
      ev      <= db & ~db_prev;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      image   <= '0;
      sel     <= '0;
      changed <= 1'b0;
      boot_r  <= 1'b0;
      busy_r  <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      image   <= image_n;
      sel     <= sel_n;
      changed <= changed_n;
      boot_r  <= boot_n;
      busy_r  <= busy_n;
      cnt     <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (ev[1]) state_n = ARM;
      ARM:     if (cnt == SETUP_LAST) state_n = FIRE;
      FIRE:    state_n = FIRE;
      default: state_n = IDLE;
    endcase
  end

  // Boot takes priority over a same-cycle increment so S1:S0 latches the pre-increment image.
  always_comb begin
    image_n   = image;
    sel_n     = sel;
    changed_n = 1'b0;
    boot_n    = boot_r;
    busy_n    = busy_r;
    cnt_n     = cnt;
    case (state)
      IDLE: begin
        sel_n = image;
        cnt_n = '0;
        if (ev[1]) begin
          busy_n = 1'b1;
        end else if (ev[0] && (NUM_IMAGES > 1)) begin
          image_n   = (image == IMG_LAST) ? 2'd0 : image + 2'd1;
          changed_n = 1'b1;
        end
      end
      ARM: begin
        if (cnt == SETUP_LAST) boot_n = 1'b1;
        else                   cnt_n  = cnt + CW'(1);
      end
      default: ;
    endcase
  end

  assign bus.image         = image;
  assign bus.image_changed = changed;
  assign bus.boot_s1       = sel[1];
  assign bus.boot_s0       = sel[0];
  assign bus.boot          = boot_r;
  assign bus.busy          = busy_r;
  assign bus.state         = state;

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Bench for warmboot_sequencer: press tables, hand-written corner sequences and
// random button activity, all checked cycle by cycle against a behavioural model.
module tb_warmboot_sequencer;

  localparam int DEB   = 4;
  localparam int SETUP = 3;
  localparam int NIMG  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  warmboot_sequencer_if bus();

  warmboot_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .SETUP_CYCLES   (SETUP),
    .NUM_IMAGES     (NIMG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: inputs seen two edges late, a level accepted after DEB
  // consecutive disagreeing samples, events acted on two edges after acceptance.
  logic [2:0] hist [2];
  logic [2:0] rise_h [2];
  logic       acc [2];
  int         run [2];
  int         m_image;
  logic [1:0] m_sel;
  logic       m_changed, m_busy, m_boot;
  int         m_k, boot_at;

  int   cyc, pulse_cnt, t_busy, t_boot;
  logic busy_seen, boot_seen;

  typedef struct {
    logic       inc;
    logic       bt;
    int         hold;
    int         gap;
    logic [1:0] exp_image;
    int         exp_pulses;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [6:0] dut_out();
    return {bus.image, bus.image_changed, bus.boot_s1, bus.boot_s0, bus.boot, bus.busy};
  endfunction

  function automatic logic [6:0] model_out();
    return {2'(m_image), m_changed, m_sel, m_boot, m_busy};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      hist[b] = '0; rise_h[b] = '0; acc[b] = 1'b0; run[b] = 0;
    end
    m_image = 0; m_sel = '0; m_changed = 1'b0; m_busy = 1'b0; m_boot = 1'b0;
    m_k = 0; boot_at = 0;
    pulse_cnt = 0; busy_seen = 1'b0; boot_seen = 1'b0; t_busy = 0; t_boot = 0;
  endtask

  task automatic model_edge(input logic inc, input logic bt);
    logic raw [2];
    logic ev [2];
    raw[0] = inc;
    raw[1] = bt;
    for (int b = 0; b < 2; b++) begin
      logic lvl, rise;
      hist[b] = {hist[b][1:0], raw[b]};
      lvl  = hist[b][2];
      rise = 1'b0;
      if (lvl != acc[b]) begin
        run[b]++;
        if (run[b] == DEB) begin
          acc[b] = lvl;
          run[b] = 0;
          rise   = lvl;
        end
      end else begin
        run[b] = 0;
      end
      rise_h[b] = {rise_h[b][1:0], rise};
      ev[b] = rise_h[b][2];
    end
    m_changed = 1'b0;
    if (!m_busy) begin
      m_sel = 2'(m_image);
      if (ev[1]) begin
        m_busy  = 1'b1;
        boot_at = m_k + SETUP + 1;
      end else if (ev[0] && NIMG > 1) begin
        m_image   = (m_image + 1) % NIMG;
        m_changed = 1'b1;
      end
    end
    m_boot = m_busy && (m_k >= boot_at);
    m_k++;
  endtask

  task automatic cycle(input logic inc, input logic bt);
    bus.btn_inc  = inc;
    bus.btn_boot = bt;
    model_edge(inc, bt);
    @(negedge clk);
    cyc++;
    if (bus.image_changed) pulse_cnt++;
    if (bus.busy && !busy_seen) begin busy_seen = 1'b1; t_busy = cyc; end
    if (bus.boot && !boot_seen) begin boot_seen = 1'b1; t_boot = cyc; end
    check("model", 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic press(input logic inc, input logic bt, input int hold, input int gap);
    repeat (hold) cycle(inc, bt);
    repeat (gap) cycle(1'b0, 1'b0);
  endtask

  // Reset is raised between clock edges and checked before the next edge arrives.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    bus.btn_inc  = 1'b0;
    bus.btn_boot = 1'b0;
    #1;
    check("async_reset", 32'(dut_out()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 10, 12, 2'd1, 1};
    vecs[1] = '{1'b1, 1'b0, 10, 12, 2'd2, 1};
    vecs[2] = '{1'b1, 1'b0, 10, 12, 2'd3, 1};
    vecs[3] = '{1'b1, 1'b0, 10, 12, 2'd0, 1};
    vecs[4] = '{1'b1, 1'b0, 10, 12, 2'd1, 1};
    vecs[5] = '{1'b1, 1'b0,  1, 12, 2'd1, 0};
    vecs[6] = '{1'b1, 1'b0,  2, 12, 2'd1, 0};
    vecs[7] = '{1'b1, 1'b0,  3, 12, 2'd1, 0};

    bus.btn_inc  = 1'b0;
    bus.btn_boot = 1'b0;
    cyc = 0;
    model_reset();
    do_reset();

    // Increment, wrap and short-pulse rejection
    for (int i = 0; i < 8; i++) begin
      pulse_cnt = 0;
      press(vecs[i].inc, vecs[i].bt, vecs[i].hold, vecs[i].gap);
      check($sformatf("vec%0d_image", i), 32'(bus.image), 32'(vecs[i].exp_image));
      check($sformatf("vec%0d_pulses", i), 32'(pulse_cnt), 32'(vecs[i].exp_pulses));
    end

    // Chatter around a long press counts once
    begin
      logic [5:0] lead;
      lead = 6'b101101;
      pulse_cnt = 0;
      for (int i = 5; i >= 0; i--) cycle(lead[i], 1'b0);
      repeat (10) cycle(1'b1, 1'b0);
      cycle(1'b0, 1'b0); cycle(1'b1, 1'b0);
      press(1'b0, 1'b0, 0, 12);
      check("chatter_image", 32'(bus.image), 32'd2);
      check("chatter_pulses", 32'(pulse_cnt), 32'd1);
    end

    // Boot from image 2 with increments arriving during ARM and FIRE
    pulse_cnt = 0;
    repeat (3) cycle(1'b0, 1'b1);
    repeat (7) cycle(1'b1, 1'b1);
    press(1'b0, 1'b0, 0, 12);
    press(1'b1, 1'b0, 10, 12);
    check("boot_image", 32'(bus.image), 32'd2);
    check("boot_sel", 32'({bus.boot_s1, bus.boot_s0}), 32'b10);
    check("boot_level", 32'({bus.boot, bus.busy}), 32'b11);
    check("boot_pulses", 32'(pulse_cnt), 32'd0);
    check("boot_latency", 32'(t_boot - t_busy), 32'(SETUP + 1));
    do_reset();

    // Simultaneous inc and boot from image 1
    press(1'b1, 1'b0, 10, 12);
    check("pre_sim_image", 32'(bus.image), 32'd1);
    pulse_cnt = 0;
    press(1'b1, 1'b1, 10, 12);
    check("sim_image", 32'(bus.image), 32'd1);
    check("sim_sel", 32'({bus.boot_s1, bus.boot_s0}), 32'b01);
    check("sim_busy", 32'(bus.busy), 32'd1);
    check("sim_pulses", 32'(pulse_cnt), 32'd0);
    do_reset();

    // Reset two cycles into ARM, then a complete boot
    for (int i = 0; i < 30 && !busy_seen; i++) cycle(1'b0, 1'b1);
    check("arm_reached", 32'(busy_seen), 32'd1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    check("arm_no_boot_yet", 32'(boot_seen), 32'd0);
    do_reset();
    press(1'b0, 1'b0, 0, 12);
    check("abort_idle", 32'({bus.busy, boot_seen}), 32'd0);
    press(1'b0, 1'b1, 10, 12);
    check("reboot_boot", 32'(bus.boot), 32'd1);
    check("reboot_latency", 32'(t_boot - t_busy), 32'(SETUP + 1));

    // Random button activity
    for (int r = 0; r < 3; r++) begin
      int start;
      do_reset();
      start = cyc;
      while (cyc - start < 400) begin
        logic inc_l, bt_l;
        int   len;
        inc_l = 1'($urandom_range(0, 1));
        bt_l  = ($urandom_range(0, 9) == 0);
        len   = $urandom_range(1, 9);
        repeat (len) cycle(inc_l, bt_l);
      end
    end
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
